// File: rtl/hermes_rx_arbiter_pkg.sv
// hermes_rx_arbiter_pkg: shared state type and counter width for the Hermes receive arbiter.
package hermes_rx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} hermes_rx_state_t;
    localparam int HERMES_RX_CNT_W = 16;
endpackage

// File: rtl/hermes_rx_arbiter_ring_buffer.sv
// hermes_rx_arbiter_ring_buffer: per-channel flit FIFO; rx_ack_o is the credit (not full), tx_o is non-empty.
module hermes_rx_arbiter_ring_buffer #(
    parameter int DATA_SIZE   = 32,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 rx_ack_o,
    output logic                 tx_o,
    input  logic                 ack_i,
    output logic [DATA_SIZE-1:0] data_o
);
    localparam int AW = $clog2(BUFFER_SIZE);
    logic [AW:0]          wr_q, rd_q;
    logic [DATA_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic                 full, empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = wr_q == rd_q;
    assign rx_ack_o = !full;
    assign tx_o     = !empty;
    assign data_o   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (rx_i && !full) wr_q <= wr_q + (AW+1)'(1);
            if (ack_i && !empty) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_i && !full) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/hermes_rx_arbiter.sv
// hermes_rx_arbiter: N-channel Hermes receive front-end, round-robin per packet into one rx/credit stream.
// Optional per-channel packet counters enabled by DMNI_RX_PKT_CNT_EN.
module hermes_rx_arbiter
    import hermes_rx_arbiter_pkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 16,
    parameter int N_CHANNELS  = 2,
    localparam int CW = N_CHANNELS > 1 ? $clog2(N_CHANNELS) : 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [N_CHANNELS-1:0]                        noc_rx_i,
    output logic [N_CHANNELS-1:0]                        noc_credit_o,
    input  logic [N_CHANNELS-1:0][FLIT_SIZE-1:0]         noc_data_i,
    output logic                                         tx_o,
    input  logic                                         credit_i,
    output logic [FLIT_SIZE-1:0]                         data_o,
    output logic [CW-1:0]                                channel_o,
    output logic                                         busy_o,
    output logic [N_CHANNELS-1:0][HERMES_RX_CNT_W-1:0]   pkt_count_o
);
    hermes_rx_state_t                    state_q;
    logic [CW-1:0]                       chan_q, rr_q, grant_d, rr_d;
    logic [FLIT_SIZE-1:0]                rem_q;
    logic [N_CHANNELS-1:0]               ne, ack;
    logic [N_CHANNELS-1:0][FLIT_SIZE-1:0] head;
    logic                                xfer, eop;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_buf
        assign ack[c] = xfer && (chan_q == CW'(c));
        hermes_rx_arbiter_ring_buffer #(.DATA_SIZE(FLIT_SIZE), .BUFFER_SIZE(BUFFER_SIZE)) u_buf (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rx_i     (noc_rx_i[c]),
            .data_i   (noc_data_i[c]),
            .rx_ack_o (noc_credit_o[c]),
            .tx_o     (ne[c]),
            .ack_i    (ack[c]),
            .data_o   (head[c])
        );
    end

    assign busy_o    = state_q != IDLE;
    assign channel_o = chan_q;
    assign tx_o      = busy_o && ne[chan_q];
    assign data_o    = busy_o ? head[chan_q] : '0;
    assign xfer      = tx_o && credit_i;
    assign eop       = xfer && ((state_q == SIZE && data_o == '0) ||
                                (state_q == PAYLOAD && rem_q == FLIT_SIZE'(1)));
    assign rr_d      = CW'((int'(chan_q) + 1) % N_CHANNELS);

    // Walk offsets from farthest to nearest so the channel closest to rr_q wins.
    always_comb begin
        grant_d = rr_q;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            grant_d = ne[(int'(rr_q) + i) % N_CHANNELS] ? CW'((int'(rr_q) + i) % N_CHANNELS) : grant_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            chan_q  <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|ne) begin
                    chan_q  <= grant_d;
                    state_q <= HEADER;
                end
                HEADER: if (xfer) state_q <= SIZE;
                SIZE: if (xfer) begin
                    rem_q   <= data_o;
                    state_q <= data_o == '0 ? IDLE : PAYLOAD;
                end
                PAYLOAD: if (xfer) begin
                    rem_q   <= rem_q - FLIT_SIZE'(1);
                    state_q <= rem_q == FLIT_SIZE'(1) ? IDLE : PAYLOAD;
                end
                default: state_q <= IDLE;
            endcase
            if (eop) rr_q <= rr_d;
        end
    end

`ifdef DMNI_RX_PKT_CNT_EN
    logic [N_CHANNELS-1:0][HERMES_RX_CNT_W-1:0] pkt_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pkt_cnt_q <= '0;
        else if (eop && pkt_cnt_q[chan_q] != '1) pkt_cnt_q[chan_q] <= pkt_cnt_q[chan_q] + HERMES_RX_CNT_W'(1);
    end

    assign pkt_count_o = pkt_cnt_q;
`else
    assign pkt_count_o = '0;
`endif
endmodule

// File: tb/tb_hermes_rx_arbiter.sv
// tb_hermes_rx_arbiter: directed scoreboard bench for hermes_rx_arbiter (N_CHANNELS=2, BUFFER_SIZE=16).
module tb_hermes_rx_arbiter;
    localparam int F = 32;
    localparam int N = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        noc_rx = '0;
    logic [N-1:0]        noc_credit;
    logic [N-1:0][F-1:0] noc_data = '0;
    logic                tx;
    logic                credit = 1'b1;
    logic [F-1:0]        data;
    logic [0:0]          chan;
    logic                busy;
    logic [N-1:0][15:0]  pkt_count;

    int errors = 0;
    int checks = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    logic [F:0] exp_q [$];
    logic [F:0] mon_e;

    always #5 clk = ~clk;

    hermes_rx_arbiter #(.FLIT_SIZE(F), .BUFFER_SIZE(16), .N_CHANNELS(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .noc_rx_i     (noc_rx),
        .noc_credit_o (noc_credit),
        .noc_data_i   (noc_data),
        .tx_o         (tx),
        .credit_i     (credit),
        .data_o       (data),
        .channel_o    (chan),
        .busy_o       (busy),
        .pkt_count_o  (pkt_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [F-1:0] d);
        exp_q.push_back({c[0], d});
    endtask

    task automatic send(input int c, input logic [F-1:0] d);
        noc_rx[c] = 1'b1;
        noc_data[c] = d;
        @(posedge clk);
        #1;
        noc_rx[c] = 1'b0;
    endtask

    task automatic send2(input logic [F-1:0] d0, input logic [F-1:0] d1);
        noc_rx = 2'b11;
        noc_data[0] = d0;
        noc_data[1] = d1;
        @(posedge clk);
        #1;
        noc_rx = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) idle(1);
        chk(tag, (exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef DMNI_RX_PKT_CNT_EN
        chk(tag, pkt_count, {cnt1[15:0], cnt0[15:0]});
`else
        chk(tag, pkt_count, 0);
`endif
    endtask

    // Scoreboard: every accepted output flit must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && tx && credit) begin
            if (exp_q.size() == 0) chk("unexpected_flit", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                chk("out_data", data, mon_e[F-1:0]);
                chk("out_channel", chan, mon_e[F]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_tx", tx, 0);
        chk("rst_data", data, 0);
        chk("rst_chan", chan, 0);
        chk("rst_busy", busy, 0);
        chk("rst_credit", noc_credit, 2'b11);
        chk("rst_cnt", pkt_count, 0);
        rst = 1'b0;
        idle(2);

        // Single packet on ch0, minimum latency
        push_exp(0, 32'h0000_0101); push_exp(0, 3);
        push_exp(0, 32'hA); push_exp(0, 32'hB); push_exp(0, 32'hC);
        send(0, 32'h0000_0101);
        chk("lat_idle_tx", tx, 0);
        send(0, 3);
        chk("lat_tx", tx, 1);
        chk("lat_busy", busy, 1);
        send(0, 32'hA); send(0, 32'hB); send(0, 32'hC);
        drain("single_drain", 20);
        cnt0++;
        chk("single_busy", busy, 0);
        chk_cnt("single_cnt");

        // Zero-size packet on ch1
        push_exp(1, 32'h0201); push_exp(1, 0);
        send(1, 32'h0201); send(1, 0);
        chk("zero_chan", chan, 1);
        drain("zero_drain", 20);
        cnt1++;
        chk_cnt("zero_cnt");

        // Contention with rr=0: ch0 packet fully before ch1
        push_exp(0, 32'h0301); push_exp(0, 2); push_exp(0, 32'h31); push_exp(0, 32'h32);
        push_exp(1, 32'h0302); push_exp(1, 2); push_exp(1, 32'h33); push_exp(1, 32'h34);
        send2(32'h0301, 32'h0302); send2(2, 2); send2(32'h31, 32'h33); send2(32'h32, 32'h34);
        chk("cont0_chan", chan, 0);
        drain("cont0_drain", 30);
        cnt0++; cnt1++;
        chk_cnt("cont0_cnt");

        // ch0 alone moves rr to 1, then contention grants ch1 first
        push_exp(0, 32'h0401); push_exp(0, 0);
        send(0, 32'h0401); send(0, 0);
        drain("rr_prep_drain", 20);
        push_exp(1, 32'h0502); push_exp(1, 1); push_exp(1, 32'h52);
        push_exp(0, 32'h0501); push_exp(0, 1); push_exp(0, 32'h51);
        send2(32'h0501, 32'h0502); send2(1, 1);
        chk("cont1_chan", chan, 1);
        send2(32'h51, 32'h52);
        drain("cont1_drain", 30);
        cnt0 += 2; cnt1++;
        chk_cnt("cont1_cnt");

        // Backpressure: fill ch1 to 16 flits, 17th refused
        credit = 1'b0;
        push_exp(1, 32'h01F1); push_exp(1, 14);
        for (int i = 1; i <= 14; i++) push_exp(1, i);
        send(1, 32'h01F1);
        chk("bp_credit_early", noc_credit[1], 1);
        send(1, 14);
        for (int i = 1; i <= 14; i++) send(1, i);
        chk("bp_full", noc_credit[1], 0);
        send(1, 32'hDEAD);
        chk("bp_full_17", noc_credit[1], 0);
        chk("bp_tx_hold", tx, 1);
        chk("bp_data_hold", data, 32'h01F1);
        idle(3);
        chk("bp_data_stable", data, 32'h01F1);
        credit = 1'b1;
        idle(1);
        chk("bp_credit_back", noc_credit[1], 1);
        drain("bp_drain", 40);
        cnt1++;
        idle(3);
        chk("bp_no_residue_tx", tx, 0);
        chk("bp_no_residue_busy", busy, 0);
        chk_cnt("bp_cnt");

        // Gapped payload on ch0 while ch1 holds a full packet
        push_exp(0, 32'h0601); push_exp(0, 4);
        push_exp(0, 32'h61); push_exp(0, 32'h62); push_exp(0, 32'h63); push_exp(0, 32'h64);
        push_exp(1, 32'h0602); push_exp(1, 1); push_exp(1, 32'h65);
        send(0, 32'h0601); send(0, 4); send(0, 32'h61); send(0, 32'h62);
        send(1, 32'h0602); send(1, 1); send(1, 32'h65);
        idle(2);
        chk("gap_tx", tx, 0);
        chk("gap_chan", chan, 0);
        chk("gap_busy", busy, 1);
        send(0, 32'h63); send(0, 32'h64);
        drain("gap_drain", 30);
        cnt0++; cnt1++;
        chk_cnt("gap_cnt");

        // Reset mid-packet drops everything, including a waiting ch1 header
        push_exp(0, 32'h0701); push_exp(0, 5); push_exp(0, 32'h71); push_exp(0, 32'h72);
        send2(32'h0701, 32'h0BAD);
        send(0, 5); send(0, 32'h71); send(0, 32'h72);
        idle(4);
        chk("pre_reset_delivered", exp_q.size(), 0);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_chan", chan, 0);
        chk("mid_rst_credit", noc_credit, 2'b11);
        chk("mid_rst_cnt", pkt_count, 0);
        exp_q.delete();
        cnt0 = 0; cnt1 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        chk("post_rst_idle", tx, 0);
        push_exp(1, 32'h0801); push_exp(1, 1); push_exp(1, 32'h81);
        send(1, 32'h0801); send(1, 1); send(1, 32'h81);
        drain("post_rst_drain", 20);
        cnt1++;
        chk_cnt("post_rst_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hermes_rx_arbiter.md
Name: hermes_rx_arbiter

Overview:
- N-channel Hermes receive front-end for the next-generation DMNI.
- Buffers flits from several Hermes physical input channels in per-channel ring buffers.
- Arbitrates round-robin at packet granularity (header, size, payload) and streams one whole packet at a time to the DMA over a single Hermes-style rx/credit interface.
- Replaces the single hermes input ring buffer in front of the DMA; adds channel count and packet framing.

Parameters:
- FLIT_SIZE, 32, Hermes flit width in bits.
- BUFFER_SIZE, 16, per-channel buffer depth in flits (power of two, >= 2).
- N_CHANNELS, 2, number of Hermes input channels (>= 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- noc_rx_i  in  N_CHANNELS  per-channel flit valid.
- noc_credit_o  out  N_CHANNELS  per-channel credit; high = buffer not full.
- noc_data_i  in  N_CHANNELS x FLIT_SIZE  per-channel flit.
- tx_o  out  1  output flit valid towards DMA.
- credit_i  in  1  DMA accepts flit.
- data_o  out  FLIT_SIZE  output flit.
- channel_o  out  max(1,$clog2(N_CHANNELS))  index of locked channel.
- busy_o  out  1  packet in progress (state != IDLE).
- pkt_count_o  out  N_CHANNELS x 16  packets delivered per channel (see Optional Feature).

Behaviour:
- Transfers: input transfer when noc_rx_i[c] && noc_credit_o[c]. Output transfer when tx_o && credit_i.
- Reset: all buffers empty; noc_credit_o all 1; tx_o=0; data_o=0; channel_o=0; busy_o=0; rr pointer=0; pkt_count_o=0; state IDLE.
- Reset mid-packet: drops all buffered flits and the partial packet; no residue after release.
- Buffers: a flit written at edge t is readable from t+1.
  - Full: credit low, no write. Empty: no read.
  - Read and write in the same cycle are legal at any non-full occupancy; occupancy is unchanged.
  - Pointers wrap modulo BUFFER_SIZE.
- FSM states IDLE, HEADER, SIZE, PAYLOAD.
  - IDLE: scan channels from rr pointer upward, wrapping. Lock the first channel with a non-empty buffer into channel_o and go to HEADER. If none is non-empty, stay in IDLE. Grant costs one cycle; no output in IDLE.
  - HEADER/SIZE/PAYLOAD: tx_o = locked buffer non-empty; data_o = head flit of locked buffer (combinational).
  - HEADER: on transfer -> SIZE.
  - SIZE: on transfer, latch the flit as remaining count (FLIT_SIZE bits). If value 0 -> IDLE (end of packet); else -> PAYLOAD.
  - PAYLOAD: each transfer decrements the count. The transfer with count==1 ends the packet -> IDLE.
  - End of packet: rr pointer = locked+1 mod N_CHANNELS. Counter for the locked channel increments.
- Other channels keep filling while locked; they are never interleaved into the current packet.
- Locked buffer empty mid-packet: tx_o=0; state holds; no timeout.
- credit_i low: data_o and tx_o hold stable until the transfer.
- Minimum latency: header flit written at t -> tx_o high at t+2 when the block is idle.
- N_CHANNELS=1: arbitration degenerates; channel_o stays 0.

Optional Feature:
- Macro DMNI_RX_PKT_CNT_EN.
- Defined: pkt_count_o[c] is a 16-bit saturating counter of completed packets from channel c (holds at 0xFFFF), cleared only by reset.
- Undefined: no counters are instantiated; pkt_count_o is tied to 0.

Decomposition:
- DMNIPkg: hermes_rx_state_t enum (IDLE, HEADER, SIZE, PAYLOAD) and HERMES_RX_CNT_W=16.
- One sub-module: RingBuffer (DATA_SIZE, BUFFER_SIZE), instantiated N_CHANNELS times via generate. It supplies rx_ack as credit and tx as non-empty.
- Arbiter, FSM and counters live in hermes_rx_arbiter.

Test Plan:
- Single channel, N_CHANNELS=2, credit_i=1: ch0 sends header 0x0000_0101, size 3, payload A,B,C -> data_o sequence 0x101,3,A,B,C. First tx_o at write+2 cycles. busy_o drops after C. pkt_count_o[0]=1.
- Contention: ch0 and ch1 each send a 2-payload packet in the same cycle, rr=0 -> ch0's packet fully delivered before any ch1 flit. channel_o 0 then 1. Next contention from ch0 and ch1 grants ch1 first.
- Zero-size packet: header, size 0 -> two output flits, FSM back to IDLE, counter increments.
- Backpressure/full: credit_i=0; ch1 writes 16 flits -> noc_credit_o[1]=0 after 16th; 17th not accepted. Release credit_i -> all 16 flits delivered in order; credit returns after first read.
- Gapped payload: ch0 stalls 5 cycles mid-payload while ch1 holds a full packet -> tx_o=0 during gap. No ch1 flit appears until ch0's packet ends.
- Reset mid-packet: assert rst_i during PAYLOAD -> outputs return to reset values immediately. After release, a new ch1 packet delivers cleanly. With DMNI_RX_PKT_CNT_EN, counters read 0.
